// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared constants and types for the writeback / register file
//            slice: geometry, register index type, NZCV flag struct and
//            the dual-slot commit priority.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int NREGS  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // When both slots target the same register, slot 2 (load result) commits.
  localparam bit SLOT2_WINS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wb_flag_reg.sv
`default_nettype none
// ============================================================================
// Module   : wb_flag_reg
// Purpose  : 4-bit NZCV architectural flag register. Each bit loads from
//            its own enable and holds otherwise. Async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module wb_flag_reg
  import wb_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  nzcv_t en,
  input  nzcv_t d,
  output nzcv_t q
);

  // Per-bit conditional load; disabled bits keep their value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      if (en.n) q.n <= d.n;
      if (en.z) q.z <= d.z;
      if (en.c) q.c <= d.c;
      if (en.v) q.v <= d.v;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Writeback stage architectural state. Commits up to two register
//            results per cycle into an NREGS x DATA_W register file (slot 2
//            wins on a same-destination collision), updates NZCV, and serves
//            four combinational decode read ports.
// Config   : WB_BYPASS_EN - when defined, same-cycle writes are forwarded to
//            all read ports and flag outputs (write-before-read).
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
  import wb_pkg::*;
#(
  parameter int NREGS  = wb_pkg::NREGS,
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p3_regWrite1,
  input  logic [ADDR_W-1:0] p3_writeReg1,
  input  logic [DATA_W-1:0] p3_aluOut,
  input  logic              p3_regWrite2,
  input  logic [ADDR_W-1:0] p3_writeReg2,
  input  logic [DATA_W-1:0] p3_memOut,
  input  logic              p3_NFlagWrite,
  input  logic              p3_ZFlagWrite,
  input  logic              p3_CFlagWrite,
  input  logic              p3_VFlagWrite,
  input  logic              p3_neg,
  input  logic              p3_zero,
  input  logic              p3_carry,
  input  logic              p3_overflow,
  input  logic [ADDR_W-1:0] rn1,
  input  logic [ADDR_W-1:0] rn2,
  input  logic [ADDR_W-1:0] rn3,
  input  logic [ADDR_W-1:0] rn4,
  output logic [DATA_W-1:0] regOut1,
  output logic [DATA_W-1:0] regOut2,
  output logic [DATA_W-1:0] regOut3,
  output logic [DATA_W-1:0] regOut4,
  output logic              flagN,
  output logic              flagZ,
  output logic              flagC,
  output logic              flagV,
  output logic              wbBusy
);

  logic [DATA_W-1:0] regs [NREGS];
  nzcv_t             flag_en;
  nzcv_t             flag_d;
  nzcv_t             flag_q;

  assign flag_en = '{n: p3_NFlagWrite, z: p3_ZFlagWrite, c: p3_CFlagWrite, v: p3_VFlagWrite};
  assign flag_d  = '{n: p3_neg,        z: p3_zero,       c: p3_carry,      v: p3_overflow};

  // Busy whenever either slot commits this cycle.
  assign wbBusy = p3_regWrite1 | p3_regWrite2;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    logic hit1_raw;
    logic hit2_raw;
    logic hit1;
    logic hit2;

    assign hit1_raw = p3_regWrite1 && (p3_writeReg1 == ADDR_W'(i));
    assign hit2_raw = p3_regWrite2 && (p3_writeReg2 == ADDR_W'(i));
    // Losing slot of a collision is dropped entirely.
    assign hit1 = hit1_raw && !(SLOT2_WINS && hit2_raw);
    assign hit2 = hit2_raw && !(!SLOT2_WINS && hit1_raw);

    // One register entry: reset clears, otherwise load from the winning slot.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        regs[i] <= '0;
      end else if (hit2) begin
        regs[i] <= p3_memOut;
      end else if (hit1) begin
        regs[i] <= p3_aluOut;
      end
    end
  end

  wb_flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .en    (flag_en),
    .d     (flag_d),
    .q     (flag_q)
  );

  // Read one port: stored value, optionally overridden by a same-cycle write.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = regs[a];
`ifdef WB_BYPASS_EN
    begin
      logic h1;
      logic h2;
      h1 = p3_regWrite1 && (p3_writeReg1 == a);
      h2 = p3_regWrite2 && (p3_writeReg2 == a);
      if (SLOT2_WINS) begin
        if (h1) r = p3_aluOut;
        if (h2) r = p3_memOut;
      end else begin
        if (h2) r = p3_memOut;
        if (h1) r = p3_aluOut;
      end
      // Forwarded data must not leak out while reset holds the state at zero.
      if (!reset) r = '0;
    end
`endif
    return r;
  endfunction

  // Four combinational decode read ports.
  always_comb begin
    regOut1 = read_port(rn1);
    regOut2 = read_port(rn2);
    regOut3 = read_port(rn3);
    regOut4 = read_port(rn4);
  end

  // Flag outputs follow the same forwarding rule as register reads.
  always_comb begin
    flagN = flag_q.n;
    flagZ = flag_q.z;
    flagC = flag_q.c;
    flagV = flag_q.v;
`ifdef WB_BYPASS_EN
    if (flag_en.n) flagN = flag_d.n;
    if (flag_en.z) flagZ = flag_d.z;
    if (flag_en.c) flagC = flag_d.c;
    if (flag_en.v) flagV = flag_d.v;
    if (!reset) begin
      flagN = 1'b0;
      flagZ = 1'b0;
      flagC = 1'b0;
      flagV = 1'b0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for wb_regfile (expected values
//            are hand-computed; forwarding expectations follow WB_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        we1, we2;
  logic [2:0]  wr1, wr2;
  logic [31:0] alu, mem;
  logic        fwn, fwz, fwc, fwv;
  logic        neg, zero, carry, ovf;
  logic [2:0]  rn1, rn2, rn3, rn4;
  logic [31:0] out1, out2, out3, out4;
  logic        fn, fz, fc, fv;
  logic        busy;

  int n_vec;
  int n_err;

  wb_regfile dut (
    .clk           (clk),
    .reset         (reset),
    .p3_regWrite1  (we1),
    .p3_writeReg1  (wr1),
    .p3_aluOut     (alu),
    .p3_regWrite2  (we2),
    .p3_writeReg2  (wr2),
    .p3_memOut     (mem),
    .p3_NFlagWrite (fwn),
    .p3_ZFlagWrite (fwz),
    .p3_CFlagWrite (fwc),
    .p3_VFlagWrite (fwv),
    .p3_neg        (neg),
    .p3_zero       (zero),
    .p3_carry      (carry),
    .p3_overflow   (ovf),
    .rn1           (rn1),
    .rn2           (rn2),
    .rn3           (rn3),
    .rn4           (rn4),
    .regOut1       (out1),
    .regOut2       (out2),
    .regOut3       (out3),
    .regOut4       (out4),
    .flagN         (fn),
    .flagZ         (fz),
    .flagC         (fc),
    .flagV         (fv),
    .wbBusy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we1 = 0; we2 = 0; wr1 = 0; wr2 = 0; alu = 0; mem = 0;
    fwn = 0; fwz = 0; fwc = 0; fwv = 0;
    neg = 0; zero = 0; carry = 0; ovf = 0;
  endtask

  // Commit on the next rising edge, then return to idle mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  function automatic logic [31:0] nzcv();
    return {28'd0, fn, fz, fc, fv};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rn1 = 3; rn2 = 0; rn3 = 5; rn4 = 7;
    reset = 1'b0;

    // Reset held with writes and flag updates active.
    we1 = 1; wr1 = 3; alu = 32'hDEADBEEF;
    we2 = 1; wr2 = 5; mem = 32'hCAFEF00D;
    fwn = 1; fwz = 1; fwc = 1; fwv = 1;
    neg = 1; zero = 1; carry = 1; ovf = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out1", out1, 32'h0);
    check("rst_out2", out2, 32'h0);
    check("rst_out3", out3, 32'h0);
    check("rst_out4", out4, 32'h0);
    check("rst_nzcv", nzcv(), 32'h0);

    // Release reset away from the edge, then write r3 via slot 1.
    @(negedge clk);
    idle();
    reset = 1'b1;
    we1 = 1; wr1 = 3; alu = 32'hDEADBEEF;
    step();
    check("wr_r3", out1, 32'hDEADBEEF);

    // Dual write.
    @(negedge clk);
    we1 = 1; wr1 = 2; alu = 32'h11;
    we2 = 1; wr2 = 5; mem = 32'h22;
    #1;
    check("busy_wr", {31'd0, busy}, 32'd1);
    step();
    check("busy_idle", {31'd0, busy}, 32'd0);
    rn1 = 2; rn2 = 5; rn3 = 3; rn4 = 0;
    #1;
    check("dual_r2", out1, 32'h11);
    check("dual_r5", out2, 32'h22);
    check("dual_r3", out3, 32'hDEADBEEF);
    check("dual_r0", out4, 32'h0);

    // Collision: slot 2 wins.
    @(negedge clk);
    we1 = 1; wr1 = 4; alu = 32'hAAAA;
    we2 = 1; wr2 = 4; mem = 32'h5555;
    step();
    rn1 = 4;
    #1;
    check("collide_r4", out1, 32'h5555);

    // Same-cycle read of a slot-2 write to r6.
    @(negedge clk);
    rn3 = 6;
    we2 = 1; wr2 = 6; mem = 32'h1234;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_same", out3, 32'h1234);
`else
    check("byp_same", out3, 32'h0);
`endif
    step();
    check("byp_next", out3, 32'h1234);

    // Bypass collision on a read port also follows slot-2 priority.
    @(negedge clk);
    rn4 = 1;
    we1 = 1; wr1 = 1; alu = 32'h0A0A;
    we2 = 1; wr2 = 1; mem = 32'h0B0B;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_coll", out4, 32'h0B0B);
`else
    check("byp_coll", out4, 32'h0);
`endif
    step();
    check("coll_r1", out4, 32'h0B0B);

    // Flags: only N enabled.
    @(negedge clk);
    fwn = 1; neg = 1; zero = 1; carry = 1; ovf = 1;
    #1;
`ifdef WB_BYPASS_EN
    check("flag_n_same", nzcv(), 32'h8);
`else
    check("flag_n_same", nzcv(), 32'h0);
`endif
    step();
    check("flag_n", nzcv(), 32'h8);
    @(negedge clk);
    fwc = 1; carry = 1;
    step();
    check("flag_nc", nzcv(), 32'hA);
    // Clearing N alone leaves C intact.
    @(negedge clk);
    fwn = 1; neg = 0; zero = 1;
    step();
    check("flag_c", nzcv(), 32'h2);

    // Mid-cycle reset pulse while slot 1 writes r1.
    @(negedge clk);
    rn1 = 1; rn2 = 3;
    we1 = 1; wr1 = 1; alu = 32'hFF;
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_r1", out1, 32'h0);
    check("mid_rst_r3", out2, 32'h0);
    check("mid_rst_flag", nzcv(), 32'h0);
    we1 = 0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_r1", out1, 32'h0);
    check("post_rst_r3", out2, 32'h0);
    check("post_rst_flag", nzcv(), 32'h0);

    // First write after reset is accepted.
    @(negedge clk);
    we1 = 1; wr1 = 7; alu = 32'h7777_0007;
    rn1 = 7;
    step();
    check("post_rst_wr", out1, 32'h7777_0007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
